// File: rtl/udma_tx_l2_arbiter_pkg.sv
// Shared helpers for the uDMA TX L2 read arbiter.
// Provides the channel-index width derivation and the channel index type.
package udma_tx_arb_pkg;

  function automatic int log2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_CH_DEF     = 4;
  localparam int LOG_N_CH_DEF = log2_min1(N_CH_DEF);

  typedef logic [LOG_N_CH_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/udma_tx_l2_arbiter_if.sv
// Channel-side and L2-side read handshake of the TX arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface udma_tx_l2_arbiter_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19
);
  logic [N_CH-1:0]            ch_req_i;
  logic [N_CH*ADDR_WIDTH-1:0] ch_addr_i;
  logic [N_CH-1:0]            ch_gnt_o;
  logic [N_CH-1:0]            ch_valid_o;
  logic [DATA_WIDTH-1:0]      ch_data_o;
  logic                       l2_req_o;
  logic [ADDR_WIDTH-1:0]      l2_addr_o;
  logic                       l2_gnt_i;
  logic                       l2_rvalid_i;
  logic [DATA_WIDTH-1:0]      l2_rdata_i;

  modport master (
    input  ch_req_i, ch_addr_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
    output ch_gnt_o, ch_valid_o, ch_data_o, l2_req_o, l2_addr_o
  );

  modport slave (
    output ch_req_i, ch_addr_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
    input  ch_gnt_o, ch_valid_o, ch_data_o, l2_req_o, l2_addr_o
  );
endinterface

// File: rtl/udma_tx_l2_arbiter_tag_fifo.sv
// Synchronous FIFO of channel indices recording the owner of each in-flight L2 read.
// Clear has priority over push and pop; storage itself is not reset.
module udma_tx_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wptr_nxt;
  logic [AW-1:0] w_rptr_nxt;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign w_wptr_nxt = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/udma_tx_l2_arbiter.sv
// Round-robin arbiter sharing one L2 read port between N_CH uDMA TX channels.
// In-order L2 responses are steered back to the owning channel through a tag FIFO.
module udma_tx_l2_arbiter
  import udma_tx_arb_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 19,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  udma_tx_l2_arbiter_if.master  bus,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int LOG_N_CH = log2_min1(N_CH);
  localparam int PW       = LOG_N_CH + 1;

  logic [LOG_N_CH-1:0] r_rr_ptr;
  logic                r_err;
  logic [LOG_N_CH-1:0] w_sel;
  logic [LOG_N_CH-1:0] w_head;
  logic [PW-1:0]       w_rr_inc;
  logic                w_found;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // Scan channels starting at the round-robin pointer; the first requester wins.
  always_comb begin
    logic [PW-1:0] w_cand;
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_cand = {1'b0, r_rr_ptr} + PW'(i);
      if (w_cand >= PW'(N_CH)) w_cand = w_cand - PW'(N_CH);
      if (!w_found && bus.ch_req_i[w_cand[LOG_N_CH-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[LOG_N_CH-1:0];
      end
    end
  end

  assign bus.l2_req_o  = w_found & ~w_full;
  assign bus.l2_addr_o = w_found ? bus.ch_addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;

  assign w_push       = bus.l2_req_o & bus.l2_gnt_i;
  assign bus.ch_gnt_o = w_push ? (N_CH'(1) << w_sel) : '0;

  // Response path is purely combinational: rvalid reaches the owner in the same cycle.
  assign w_pop          = bus.l2_rvalid_i & ~w_empty;
  assign bus.ch_valid_o = w_pop ? (N_CH'(1) << w_head) : '0;
  assign bus.ch_data_o  = w_pop ? bus.l2_rdata_i : '0;

  assign busy_o = ~w_empty;
  assign err_o  = r_err;

  assign w_rr_inc = {1'b0, w_sel} + PW'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else if (clr_i) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_rr_ptr <= (w_rr_inc == PW'(N_CH)) ? '0 : w_rr_inc[LOG_N_CH-1:0];
      if (bus.l2_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

  udma_tx_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (LOG_N_CH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_clr   (clr_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_sel),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_udma_tx_l2_arbiter.sv
// Directed bench for the uDMA TX L2 arbiter: fairness, routing, full stall,
// wrap with sparse requests, error/clear and asynchronous reset.
module tb_udma_tx_l2_arbiter;
  import udma_tx_arb_pkg::*;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 19;
  localparam int MO   = 4;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  logic clr_i  = 1'b0;
  logic busy_o;
  logic err_o;

  int total = 0;
  int bad   = 0;

  udma_tx_l2_arbiter_if #(.N_CH(N_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  udma_tx_l2_arbiter #(
    .N_CH(N_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (clr_i),
    .bus    (bif),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [AW-1:0] ch_addr(input int k);
    return AW'(32'h1000 + k * 32'h111);
  endfunction

  function automatic logic [N_CH-1:0] oh(input int k);
    ch_idx_t idx;
    idx = ch_idx_t'(k % N_CH);
    return N_CH'(1) << idx;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bif.ch_req_i    = '0;
    bif.l2_gnt_i    = 1'b0;
    bif.l2_rvalid_i = 1'b0;
    bif.l2_rdata_i  = '0;
    for (int k = 0; k < N_CH; k++) bif.ch_addr_i[k*AW +: AW] = ch_addr(k);

    // Reset state
    #2;
    chk("rst_l2_req",   64'(bif.l2_req_o),   64'd0);
    chk("rst_l2_addr",  64'(bif.l2_addr_o),  64'd0);
    chk("rst_gnt",      64'(bif.ch_gnt_o),   64'd0);
    chk("rst_valid",    64'(bif.ch_valid_o), 64'd0);
    chk("rst_data",     64'(bif.ch_data_o),  64'd0);
    chk("rst_busy",     64'(busy_o),         64'd0);
    chk("rst_err",      64'(err_o),          64'd0);
    #1 rstn_i = 1'b1;
    tick();

    // Fairness with overlapping responses
    bif.ch_req_i = 4'b1111;
    bif.l2_gnt_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bif.l2_rvalid_i = (c >= 1);
      bif.l2_rdata_i  = 32'hD000 + 32'(c);
      #1;
      chk($sformatf("fair_gnt%0d", c),  64'(bif.ch_gnt_o),  64'(oh(c)));
      chk($sformatf("fair_addr%0d", c), 64'(bif.l2_addr_o), 64'(ch_addr(c % N_CH)));
      chk($sformatf("fair_req%0d", c),  64'(bif.l2_req_o),  64'd1);
      chk($sformatf("fair_vld%0d", c),  64'(bif.ch_valid_o), (c >= 1) ? 64'(oh(c - 1)) : 64'd0);
      chk($sformatf("fair_dat%0d", c),  64'(bif.ch_data_o),  (c >= 1) ? 64'(32'hD000 + 32'(c)) : 64'd0);
      tick();
    end
    bif.ch_req_i    = '0;
    bif.l2_gnt_i    = 1'b0;
    bif.l2_rvalid_i = 1'b1;
    bif.l2_rdata_i  = 32'hBEEF;
    #1;
    chk("fair_last_vld", 64'(bif.ch_valid_o), 64'b0001);
    chk("fair_last_dat", 64'(bif.ch_data_o),  64'hBEEF);
    chk("fair_busy",     64'(busy_o),         64'd1);
    tick();
    bif.l2_rvalid_i = 1'b0;
    #1;
    chk("fair_idle_busy", 64'(busy_o), 64'd0);

    // Routing: rr_ptr=1, grant ch2 then ch0, responses two cycles later
    bif.ch_req_i = 4'b0100;
    bif.l2_gnt_i = 1'b1;
    #1;
    chk("route_gnt2", 64'(bif.ch_gnt_o), 64'b0100);
    tick();
    bif.ch_req_i = 4'b0001;
    #1;
    chk("route_gnt0", 64'(bif.ch_gnt_o), 64'b0001);
    tick();
    bif.ch_req_i    = '0;
    bif.l2_gnt_i    = 1'b0;
    bif.l2_rvalid_i = 1'b1;
    bif.l2_rdata_i  = 32'hAAAA;
    #1;
    chk("route_vld2", 64'(bif.ch_valid_o), 64'b0100);
    chk("route_dat2", 64'(bif.ch_data_o),  64'hAAAA);
    tick();
    bif.l2_rdata_i = 32'h5555;
    #1;
    chk("route_vld0", 64'(bif.ch_valid_o), 64'b0001);
    chk("route_dat0", 64'(bif.ch_data_o),  64'h5555);
    tick();
    bif.l2_rvalid_i = 1'b0;

    // Full stall: rr_ptr=1, four grants fill the tag FIFO
    bif.ch_req_i = 4'b1111;
    bif.l2_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("full_gnt%0d", c), 64'(bif.ch_gnt_o), 64'(oh(c + 1)));
      tick();
    end
    #1;
    chk("full_req",  64'(bif.l2_req_o), 64'd0);
    chk("full_gnt",  64'(bif.ch_gnt_o), 64'd0);
    chk("full_busy", 64'(busy_o),       64'd1);
    bif.l2_rvalid_i = 1'b1;
    bif.l2_rdata_i  = 32'h1111;
    #1;
    chk("full_pop_vld", 64'(bif.ch_valid_o), 64'b0010);
    chk("full_pop_gnt", 64'(bif.ch_gnt_o),   64'd0);
    tick();
    bif.l2_rvalid_i = 1'b0;
    #1;
    chk("full_resume_req", 64'(bif.l2_req_o), 64'd1);
    chk("full_resume_gnt", 64'(bif.ch_gnt_o), 64'b0010);
    tick();
    bif.ch_req_i    = '0;
    bif.l2_gnt_i    = 1'b0;
    bif.l2_rvalid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("full_drain%0d", c), 64'(bif.ch_valid_o), 64'(oh(c + 2)));
      tick();
    end
    bif.l2_rvalid_i = 1'b0;
    #1;
    chk("full_drained_busy", 64'(busy_o), 64'd0);

    // Wrap and sparse requests: rr_ptr=2, move it to 3 first
    bif.ch_req_i = 4'b0100;
    bif.l2_gnt_i = 1'b1;
    #1;
    chk("wrap_pre_gnt", 64'(bif.ch_gnt_o), 64'b0100);
    tick();
    bif.ch_req_i    = '0;
    bif.l2_gnt_i    = 1'b0;
    bif.l2_rvalid_i = 1'b1;
    #1;
    chk("wrap_pre_vld", 64'(bif.ch_valid_o), 64'b0100);
    tick();
    bif.l2_rvalid_i = 1'b0;
    bif.ch_req_i    = 4'b0010;
    bif.l2_gnt_i    = 1'b1;
    #1;
    chk("wrap_gnt1", 64'(bif.ch_gnt_o), 64'b0010);
    tick();
    bif.ch_req_i = 4'b1010;
    bif.l2_gnt_i = 1'b0;
    #1;
    chk("wrap_ptr2_addr", 64'(bif.l2_addr_o), 64'(ch_addr(3)));
    bif.ch_req_i = 4'b1000;
    bif.l2_gnt_i = 1'b1;
    #1;
    chk("wrap_gnt3", 64'(bif.ch_gnt_o), 64'b1000);
    tick();
    bif.ch_req_i = 4'b1111;
    bif.l2_gnt_i = 1'b0;
    #1;
    chk("wrap_ptr0_addr", 64'(bif.l2_addr_o), 64'(ch_addr(0)));
    bif.ch_req_i    = '0;
    bif.l2_rvalid_i = 1'b1;
    #1;
    chk("wrap_vld1", 64'(bif.ch_valid_o), 64'b0010);
    tick();
    #1;
    chk("wrap_vld3", 64'(bif.ch_valid_o), 64'b1000);
    tick();
    bif.l2_rvalid_i = 1'b0;

    // Error on empty FIFO, sticky until clear
    bif.ch_req_i = 4'b0010;
    bif.l2_gnt_i = 1'b1;
    tick();
    bif.ch_req_i    = '0;
    bif.l2_gnt_i    = 1'b0;
    bif.l2_rvalid_i = 1'b1;
    tick();
    bif.l2_rdata_i = 32'hE;
    #1;
    chk("err_vld_none", 64'(bif.ch_valid_o), 64'd0);
    chk("err_pre",      64'(err_o),          64'd0);
    tick();
    bif.l2_rvalid_i = 1'b0;
    #1;
    chk("err_set", 64'(err_o), 64'd1);
    tick();
    chk("err_sticky", 64'(err_o), 64'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    #1;
    chk("clr_err",  64'(err_o),  64'd0);
    chk("clr_busy", 64'(busy_o), 64'd0);
    bif.ch_req_i = 4'b1111;
    #1;
    chk("clr_ptr_addr", 64'(bif.l2_addr_o), 64'(ch_addr(0)));
    chk("clr_req",      64'(bif.l2_req_o),  64'd1);
    bif.ch_req_i = '0;

    // Asynchronous reset with three reads outstanding and err set
    bif.l2_rvalid_i = 1'b1;
    tick();
    bif.l2_rvalid_i = 1'b0;
    bif.ch_req_i    = 4'b1111;
    bif.l2_gnt_i    = 1'b1;
    tick();
    tick();
    tick();
    bif.ch_req_i = '0;
    bif.l2_gnt_i = 1'b0;
    #1;
    chk("arst_pre_busy", 64'(busy_o), 64'd1);
    chk("arst_pre_err",  64'(err_o),  64'd1);
    rstn_i = 1'b0;
    #1;
    chk("arst_busy",  64'(busy_o),         64'd0);
    chk("arst_err",   64'(err_o),          64'd0);
    chk("arst_req",   64'(bif.l2_req_o),   64'd0);
    chk("arst_addr",  64'(bif.l2_addr_o),  64'd0);
    chk("arst_gnt",   64'(bif.ch_gnt_o),   64'd0);
    chk("arst_vld",   64'(bif.ch_valid_o), 64'd0);
    chk("arst_data",  64'(bif.ch_data_o),  64'd0);
    #10;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
